// File: rtl/isqrt_pkg.sv
// Shared types and width helpers for the serial integer square-root unit.
package isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned res_w(input int unsigned width);
    return width / 2;
  endfunction

  function automatic int unsigned rem_w(input int unsigned width);
    return width / 2 + 2;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width / 2);
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring radix-4 square-root iteration: brings in two radicand bits, yields one root bit.
module isqrt_step #(
  parameter int unsigned QW = 16
) (
  input  logic [QW+1:0] i_rem,
  input  logic [QW-1:0] i_root,
  input  logic [1:0]    i_bits,
  output logic [QW+1:0] o_rem,
  output logic [QW-1:0] o_root
);

  localparam int unsigned RW = QW + 2;

  logic [RW-1:0] w_rem_sh;
  logic [RW-1:0] w_trial;
  logic          w_ge;

  assign w_rem_sh = {i_rem[RW-3:0], i_bits};
  assign w_trial  = {i_root, 2'b01};
  // Compare on the untruncated shifted value; the dropped bits are zero for in-range operands.
  assign w_ge     = {i_rem, i_bits} >= {2'b00, w_trial};
  assign o_rem    = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
  assign o_root   = {i_root[QW-2:0], w_ge};

endmodule

// File: rtl/isqrt_serial.sv
// Serial floor(sqrt(x)) responder, one result bit per clock.
// Optional ISQRT_SERIAL_BACK_TO_BACK_EN accepts a new request in the DONE cycle.
module isqrt_serial
  import isqrt_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               x_vld,
  input  logic [WIDTH-1:0]   x,
  output logic               y_vld,
  output logic [WIDTH/2-1:0] y,
  output logic               busy
);

  localparam int unsigned QW = res_w(WIDTH);
  localparam int unsigned RW = rem_w(WIDTH);
  localparam int unsigned CW = cnt_w(WIDTH);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_rad;
  logic [RW-1:0]   r_rem;
  logic [QW-1:0]   r_root;
  logic [QW-1:0]   r_y;
  logic [RW-1:0]   w_rem_nxt;
  logic [QW-1:0]   w_root_nxt;
  logic            w_accept;
  logic            w_last;

  isqrt_step #(
    .QW(QW)
  ) u_step (
    .i_rem  (r_rem),
    .i_root (r_root),
    .i_bits (r_rad[WIDTH-1 -: 2]),
    .o_rem  (w_rem_nxt),
    .o_root (w_root_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (x_vld) begin
          w_accept    = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        if (r_cnt == '0) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
`ifdef ISQRT_SERIAL_BACK_TO_BACK_EN
        if (x_vld) begin
          w_accept    = 1'b1;
          w_state_nxt = CALC;
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_rad  <= '0;
      r_rem  <= '0;
      r_root <= '0;
      r_y    <= '0;
    end else begin
      if (w_accept) begin
        r_rad  <= x;
        r_rem  <= '0;
        r_root <= '0;
        r_cnt  <= CW'(QW - 1);
      end else if (r_state == CALC) begin
        r_rad  <= {r_rad[WIDTH-3:0], 2'b00};
        r_rem  <= w_rem_nxt;
        r_root <= w_root_nxt;
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
      if (w_last) begin
        r_y <= w_root_nxt;
      end
    end
  end

  assign y_vld = (r_state == DONE);
  assign y     = r_y;
`ifdef ISQRT_SERIAL_BACK_TO_BACK_EN
  assign busy  = (r_state == CALC);
`else
  assign busy  = (r_state != IDLE);
`endif

endmodule

// File: tb/tb_isqrt_serial.sv
// Self-checking bench for isqrt_serial: timing/value model plus directed literal checks.
module tb_isqrt_serial;

  localparam int unsigned W = 32;
  localparam int unsigned H = W / 2;
`ifdef ISQRT_SERIAL_BACK_TO_BACK_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         x_vld = 1'b0;
  logic [W-1:0] x     = '0;
  logic         y_vld;
  logic [H-1:0] y;
  logic         busy;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int n_res    = 0;

  isqrt_serial #(
    .WIDTH(W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x_vld (x_vld),
    .x     (x),
    .y_vld (y_vld),
    .y     (y),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Largest r with r*r <= v, found by binary search.
  function automatic logic [H-1:0] ref_isqrt(input logic [W-1:0] v);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = (longint'(1) << H) - 1;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(v)) lo = mid;
      else hi = mid - 1;
    end
    return H'(lo);
  endfunction

  // Model: m_phase counts cycles since acceptance (0 = idle, H+1 = result cycle).
  int           m_phase;
  logic [H-1:0] m_pend;
  logic [H-1:0] m_y;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_pend  <= '0;
      m_y     <= '0;
    end else begin
      if (x_vld && (m_phase == 0 || (BTB && m_phase == H + 1))) begin
        m_phase <= 1;
        m_pend  <= ref_isqrt(x);
      end else if (m_phase == H + 1) begin
        m_phase <= 0;
      end else if (m_phase > 0) begin
        m_phase <= m_phase + 1;
      end
      if (m_phase == H) m_y <= m_pend;
    end
  end

  always @(negedge clk) begin
    chk("model_y_vld", y_vld, m_phase == H + 1);
    chk("model_busy", busy, (m_phase != 0) && !(BTB && m_phase == H + 1));
    chk("model_y", y, m_y);
    chk("y_known", $isunknown(y), 0);
    if (y_vld) n_res++;
  end

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!busy) return;
      @(posedge clk); #1;
    end
    chk("idle_timeout", 1, 0);
  endtask

  task automatic drive_req(input logic [W-1:0] v, output int t);
    x_vld = 1'b1;
    x     = v;
    t     = cyc;
    @(posedge clk); #1;
    x_vld = 1'b0;
    x     = $urandom;
  endtask

  task automatic one(input logic [W-1:0] v, input logic [H-1:0] exp);
    int t, lat;
    bit ok;
    logic [H-1:0] yv;
    wait_idle();
    drive_req(v, t);
    ok = 1'b0; lat = 0; yv = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (y_vld) begin
        ok = 1'b1; lat = cyc - t; yv = y;
        break;
      end
    end
    chk("vld_seen", ok, 1);
    chk("latency", lat, H + 1);
    chk("y_value", yv, exp);
    @(posedge clk); #1;
  endtask

  logic [W-1:0] r32;

  initial begin
    int t, nv;
    // Reset state.
    @(negedge clk);
    chk("rst_y_vld", y_vld, 0);
    chk("rst_y", y, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    one(32'd0, 16'd0);
    one(32'd16, 16'd4);
    one(32'd15, 16'd3);
    one(32'd17, 16'd4);
    one(32'hFFFF_FFFF, 16'hFFFF);
    one(32'hFFFE_0001, 16'hFFFF);
    one(32'hFFFE_0000, 16'hFFFE);

    // Requests while busy must be ignored.
    wait_idle();
    x_vld = 1'b1; x = 32'd100; t = cyc; nv = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      x_vld = (k == 5 || k == 17);
      x     = (k == 5 || k == 17) ? 32'd9 : $urandom;
      @(negedge clk);
      if (k <= 16) chk("busy_calc", busy, 1);
      if (k == 17) begin
        chk("busy_done", busy, !BTB);
        chk("busy_y_vld", y_vld, 1);
        chk("busy_y", y, 10);
      end
      if (k > 17 && y_vld) nv++;
    end
    chk("busy_extra_vld", nv, BTB ? 1 : 0);
    @(posedge clk); #1;
    x_vld = 1'b0;

    // Reset in the middle of an operation.
    wait_idle();
    x_vld = 1'b1; x = 32'd1000000; t = cyc; nv = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      x_vld = 1'b0;
      if (k == 8) rst_n = 1'b0;
      if (k == 10) rst_n = 1'b1;
      @(negedge clk);
      if (y_vld) nv++;
      if (k == 12) begin
        chk("post_rst_y", y, 0);
        chk("post_rst_busy", busy, 0);
      end
    end
    chk("rst_no_vld", nv, 0);
    @(posedge clk); #1;
    one(32'd49, 16'd7);

    // Request presented in the DONE cycle.
    wait_idle();
    x_vld = 1'b1; x = 32'd81; t = cyc; nv = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      x_vld = (k == 17);
      x     = (k == 17) ? 32'd144 : $urandom;
      @(negedge clk);
      if (k == 17) begin
        chk("b2b_vld17", y_vld, 1);
        chk("b2b_y17", y, 9);
      end
      if (k == 34) begin
        chk("b2b_vld34", y_vld, BTB);
        chk("b2b_y34", y, BTB ? 12 : 9);
      end
      if (k > 17 && y_vld) nv++;
    end
    chk("b2b_extra_vld", nv, BTB ? 1 : 0);
    @(posedge clk); #1;
    x_vld = 1'b0;

    // Random traffic, including strobes while busy; the model checks every cycle.
    n_res = 0;
    for (int c = 0; c < 40000; c++) begin
      @(posedge clk); #1;
      x_vld = ($urandom_range(0, 3) != 0);
      r32   = 32'($urandom_range(0, 65535));
      case ($urandom_range(0, 4))
        0: x = $urandom;
        1: x = r32 * r32;
        2: x = r32 * r32 - 32'd1;
        3: x = 32'($urandom_range(0, 300));
        default: x = 32'hFFFF_FFFF - 32'($urandom_range(0, 131072));
      endcase
    end
    @(posedge clk); #1;
    x_vld = 1'b0;
    chk("rand_activity", n_res > 1500, 1);
    repeat (25) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
